// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } spi_arb_state_e;

  // Limits a requested bit count to the core's word width.
  function automatic int unsigned clamp_bits(input int unsigned bits,
                                             input int unsigned max_bits);
    return (bits > max_bits) ? max_bits : bits;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant_i) + 32'(k)) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        grant_idx_o     = cand;
        grant_oh_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_core between NUM_REQ requesters: round-robin grant,
// write/read phase sequencing, per-phase watchdog and one-cycle response.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int BITWIDTH             = 8,
  parameter int P_VALID_BIT_BITWIDTH = $clog2(BITWIDTH) + 1,
  parameter int TIMEOUT_CYCLES       = 65535
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    en_i,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ*BITWIDTH-1:0]             req_sdata_i,
  input  logic [NUM_REQ*P_VALID_BIT_BITWIDTH-1:0] req_wbits_i,
  input  logic [NUM_REQ*P_VALID_BIT_BITWIDTH-1:0] req_rbits_i,
  output logic [NUM_REQ-1:0]                      rsp_valid_o,
  output logic [BITWIDTH-1:0]                     rsp_rdata_o,
  output logic                                    rsp_err_o,
  output logic                                    busy_o,
  output logic                                    core_sys_en_o,
  output logic                                    core_w_en_o,
  output logic [BITWIDTH-1:0]                     core_sdata_o,
  output logic [P_VALID_BIT_BITWIDTH-1:0]         core_sdata_valid_bit_num_o,
  input  logic                                    core_w_done_i,
  output logic                                    core_r_en_o,
  output logic [P_VALID_BIT_BITWIDTH-1:0]         core_rdata_valid_bit_num_o,
  input  logic [BITWIDTH-1:0]                     core_rdata_i,
  input  logic                                    core_rdone_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VBW   = P_VALID_BIT_BITWIDTH;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  spi_arb_state_e r_state, w_state_nxt;

  logic [IDX_W-1:0]    r_gidx;
  logic [IDX_W-1:0]    r_last_grant;
  logic [BITWIDTH-1:0] r_sdata;
  logic [VBW-1:0]      r_wbits;
  logic [VBW-1:0]      r_rbits;
  logic [BITWIDTH-1:0] r_rdata;
  logic                r_err;
  logic [WD_W-1:0]     r_wd_cnt;

  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_any;
  logic                w_grant_fire;
  logic                w_timeout;
  logic                w_wd_clear;
  logic [BITWIDTH-1:0] w_sdata_sel;
  logic [VBW-1:0]      w_wbits_sel;
  logic [VBW-1:0]      w_rbits_sel;

  logic [BITWIDTH-1:0] w_sdata_arr [NUM_REQ];
  logic [VBW-1:0]      w_wbits_arr [NUM_REQ];
  logic [VBW-1:0]      w_rbits_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_sdata_arr[gi] = req_sdata_i[gi*BITWIDTH +: BITWIDTH];
    assign w_wbits_arr[gi] = VBW'(clamp_bits(32'(req_wbits_i[gi*VBW +: VBW]), BITWIDTH));
    assign w_rbits_arr[gi] = VBW'(clamp_bits(32'(req_rbits_i[gi*VBW +: VBW]), BITWIDTH));
  end

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i        (req_valid_i),
    .last_grant_i (r_last_grant),
    .grant_oh_o   (w_grant_oh),
    .grant_idx_o  (w_grant_idx),
    .any_o        (w_any)
  );

  assign w_sdata_sel = w_sdata_arr[w_grant_idx];
  assign w_wbits_sel = w_wbits_arr[w_grant_idx];
  assign w_rbits_sel = w_rbits_arr[w_grant_idx];
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == WD_LAST);
  assign w_wd_clear  = (w_state_nxt != r_state) && ((w_state_nxt == WRITE) || (w_state_nxt == READ));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_fire = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en_i && w_any) begin
          w_grant_fire = 1'b1;
          if (w_wbits_sel != '0)      w_state_nxt = WRITE;
          else if (w_rbits_sel != '0) w_state_nxt = READ;
          else                        w_state_nxt = RESP;
        end
      end
      WRITE: begin
        // A done in the timeout cycle still counts as success.
        if (core_w_done_i)  w_state_nxt = (r_rbits != '0) ? READ : RESP;
        else if (w_timeout) w_state_nxt = RESP;
      end
      READ:    if (core_rdone_i || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gidx       <= '0;
      r_last_grant <= LAST_RST;
      r_sdata      <= '0;
      r_wbits      <= '0;
      r_rbits      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_wd_cnt     <= '0;
    end else begin
      if (w_grant_fire) begin
        r_gidx  <= w_grant_idx;
        r_sdata <= w_sdata_sel;
        r_wbits <= w_wbits_sel;
        r_rbits <= w_rbits_sel;
        r_rdata <= '0;
        r_err   <= 1'b0;
      end

      if (w_wd_clear)                               r_wd_cnt <= '0;
      else if ((r_state == WRITE) || (r_state == READ)) r_wd_cnt <= r_wd_cnt + 1'b1;

      if ((r_state == WRITE) && !core_w_done_i && w_timeout) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end

      if (r_state == READ) begin
        if (core_rdone_i) begin
          r_rdata <= core_rdata_i;
        end else if (w_timeout) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end

      if (r_state == RESP) r_last_grant <= r_gidx;
    end
  end

  assign req_ready_o                = w_grant_fire ? w_grant_oh : '0;
  assign rsp_valid_o                = (r_state == RESP) ? (NUM_REQ'(1) << r_gidx) : '0;
  assign rsp_rdata_o                = (r_state == RESP) ? r_rdata : '0;
  assign rsp_err_o                  = (r_state == RESP) && r_err;
  assign busy_o                     = (r_state != IDLE);
  assign core_sys_en_o              = en_i | busy_o;
  assign core_w_en_o                = (r_state == WRITE);
  assign core_r_en_o                = (r_state == READ);
  assign core_sdata_o               = r_sdata;
  assign core_sdata_valid_bit_num_o = r_wbits;
  assign core_rdata_valid_bit_num_o = r_rbits;

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one spi_core instance between NUM_REQ independent requesters.
- Each requester submits a transaction: an optional write phase (sdata, bit count), then an optional read phase (bit count).
- The block arbitrates round-robin, sequences the core's w_en/r_en handshakes, and returns read data and an error flag to the granted requester.
- It sits between the system-side clients and spi_core. A watchdog aborts hung transactions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BITWIDTH, 8, SPI word width; must match spi_core.
- P_VALID_BIT_BITWIDTH, $clog2(BITWIDTH)+1, width of the bit-count fields.
- TIMEOUT_CYCLES, 65535, per-phase watchdog limit in clk cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  arbiter enable; low blocks new grants, but an in-flight transaction completes
- req_valid_i  in  NUM_REQ  per-requester request pending
- req_ready_o  out  NUM_REQ  one-hot acceptance pulse
- req_sdata_i  in  NUM_REQ*BITWIDTH  packed write data, requester i at [i*BITWIDTH +: BITWIDTH]
- req_wbits_i  in  NUM_REQ*P_VALID_BIT_BITWIDTH  packed write bit counts; 0 skips the write phase
- req_rbits_i  in  NUM_REQ*P_VALID_BIT_BITWIDTH  packed read bit counts; 0 skips the read phase
- rsp_valid_o  out  NUM_REQ  one-hot completion pulse
- rsp_rdata_o  out  BITWIDTH  shared read data, valid with rsp_valid_o
- rsp_err_o  out  1  timeout flag, valid with rsp_valid_o
- busy_o  out  1  high whenever state != IDLE
- core_sys_en_o  out  1  equals en_i OR busy_o
- core_w_en_o  out  1  to spi_core w_en_i
- core_sdata_o  out  BITWIDTH  to spi_core sdata_i
- core_sdata_valid_bit_num_o  out  P_VALID_BIT_BITWIDTH  to spi_core
- core_w_done_i  in  1  from spi_core w_done_o
- core_r_en_o  out  1  to spi_core r_en_i
- core_rdata_valid_bit_num_o  out  P_VALID_BIT_BITWIDTH  to spi_core
- core_rdata_i  in  BITWIDTH  from spi_core rdata_o
- core_rdone_i  in  1  from spi_core rdone_o

Behaviour:
- Reset: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority).
  - All outputs 0: req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o, core_w_en_o, core_r_en_o, core_sdata_o, both core bit counts.
- Reset mid-transaction: core enables drop asynchronously, no response is issued, and the captured request is discarded.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - Enters arbitration when en_i=1 and req_valid_i!=0.
  - Grant g is the first set bit searching from last_grant+1 with wrap-around.
  - req_ready_o[g]=1 combinationally in this same cycle (cycle T).
  - At T the block registers g, sdata, wbits and rbits.
  - Next state: WRITE if wbits!=0, else READ if rbits!=0, else RESP (a null transaction).
- Bit counts: values above BITWIDTH are clamped to BITWIDTH at capture.
- WRITE:
  - core_w_en_o=1 from cycle T+1.
  - core_sdata_o and core_sdata_valid_bit_num_o hold the captured values.
  - On core_w_done_i=1: go to READ if rbits!=0, else RESP. core_w_en_o is low the following cycle.
- READ:
  - core_r_en_o=1, core_rdata_valid_bit_num_o=captured rbits.
  - On core_rdone_i=1: rdata_r<=core_rdata_i, then go to RESP.
- RESP (exactly one cycle):
  - rsp_valid_o[g]=1, rsp_rdata_o=rdata_r, rsp_err_o=err_r.
  - last_grant<=g, then return to IDLE. The next grant can occur on the following cycle.
- rdata_r is cleared at every grant, so write-only and null transactions return 0.
- Watchdog:
  - Counter clears on entry to WRITE or READ and increments each cycle in that state.
  - When count==TIMEOUT_CYCLES-1 with no done seen: err_r<=1, rdata_r<=0, go to RESP and skip any remaining phase.
  - A done pulse in the same cycle as the timeout wins; no error is flagged.
- Done pulses arriving in a state not waiting for them (IDLE, RESP, or the wrong phase) are ignored.
- Requests whose req_valid_i drops before grant are simply not considered. Payload needs to be stable only in the grant cycle.
- en_i falling mid-transaction: has no effect until the FSM returns to IDLE.
- Minimum latency for a null transaction: ready at T, rsp_valid at T+1.

Decomposition:
- Package spi_pkg holds:
  - the state enum typedef spi_arb_state_e (IDLE, WRITE, READ, RESP);
  - a localparam function that clamps a bit count to BITWIDTH.
- Sub-module spi_rr_arbiter: combinational round-robin picker.
  - Inputs: req vector, last_grant index.
  - Outputs: one-hot grant, grant index, any.
  - Parameterised by NUM_REQ.

Test Plan:
- Single request 0 (sdata=0xA5, wbits=8, rbits=0), core model pulses w_done 20 cycles after w_en → ready[0] at T; core_w_en_o high from T+1 until the done cycle; rsp_valid[0] one cycle later, rsp_err=0, rdata=0.
- All four requesters valid continuously with 3 transactions each → grant order 0,1,2,3,0,1,2,3,0,1,2,3; never two grants back to back to the same index while others wait.
- Requester 2 (wbits=8, rbits=8), core model returns 0x3C on rdone → w_en phase followed by r_en phase with no overlap; core_rdata_valid_bit_num_o=8; rsp_rdata=0x3C on rsp_valid[2].
- TIMEOUT_CYCLES=16, core never asserts w_done → core_w_en_o high for exactly 16 cycles; rsp_valid with rsp_err=1, rdata=0; a subsequent good request completes with err=0.
- wbits=0, rbits=0 on requester 1 → rsp_valid[1] the cycle after ready[1]; no core enable toggles. Separately, wbits=15 with BITWIDTH=8 → core_sdata_valid_bit_num_o=8.
- Assert rst_n low during the READ phase → core_r_en_o falls asynchronously; no rsp_valid_o; after release, the first grant goes to requester 0.
